// File: rtl/n2w_pkg.sv
// Shared constants and helpers for the narrow-to-wide beat packer.
// Pure package: no logic, no latency, no backpressure of its own.
// Used by narrow2wide_pack and n2w_out_reg.
package n2w_pkg;

    localparam int N2W_NW_DEF    = 4;
    localparam int N2W_RATIO_DEF = 2;

    // Counter width for 0..n-1, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // n ones in the low bits; callers cast down to their lane count.
    function automatic logic [31:0] keep_therm(input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/n2w_out_reg.sv
// One-entry output holding register for the packed word.
// Latency: loaded word visible the cycle after the load edge.
// Backpressure: can_load is low while a word is held and out_ready is low.
module n2w_out_reg #(
    parameter int WW    = 8,
    parameter int RATIO = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WW-1:0]    load_data,
    input  logic [RATIO-1:0] load_keep,
    input  logic             load_last,
    output logic             can_load,
    output logic [WW-1:0]    out_data,
    output logic [RATIO-1:0] out_keep,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    assign can_load = !out_valid || out_ready;

    // A load on the same edge as a drain replaces the word without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/narrow2wide_pack.sv
// Packs RATIO narrow beats into one wide word; in_last flushes a zero-padded partial word.
// Latency: word valid one cycle after its completing beat. Optional N2W_WORD_CNT_EN adds word_cnt.
// Backpressure: in_ready = !out_valid || out_ready; a held word stalls the input.
module narrow2wide_pack
    import n2w_pkg::*;
#(
    parameter int NW        = N2W_NW_DEF,
    parameter int RATIO     = N2W_RATIO_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NW-1:0]       in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [NW*RATIO-1:0] out_data,
    output logic [RATIO-1:0]    out_keep,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready
`ifdef N2W_WORD_CNT_EN
    ,
    output logic [15:0]         word_cnt
`endif
);

    localparam int WW = NW * RATIO;
    localparam int CW = clog2(RATIO);

    logic [CW-1:0]    cnt;
    logic [WW-1:0]    acc;
    logic [WW-1:0]    merged;
    logic [RATIO-1:0] keep_new;
    logic             accept;
    logic             complete;

    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (cnt == CW'(RATIO - 1)));
    assign keep_new = RATIO'(keep_therm(int'(cnt) + 1));

    // Lanes past cnt are still zero in acc, so a flushed partial word is padded.
    always_comb begin
        merged = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) == cnt) begin
                if (MSB_FIRST != 0) merged[WW-1-k*NW -: NW] = in_data;
                else                merged[k*NW +: NW]      = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            if (complete) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + CW'(1);
                acc <= merged;
            end
        end
    end

    n2w_out_reg #(
        .WW    (WW),
        .RATIO (RATIO)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (complete),
        .load_data (merged),
        .load_keep (keep_new),
        .load_last (in_last),
        .can_load  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

`ifdef N2W_WORD_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                      word_cnt <= '0;
        else if (out_valid && out_ready) word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_narrow2wide_pack.sv
// Bench for narrow2wide_pack: MSB-first and LSB-first instances share one stimulus stream.
module tb_narrow2wide_pack;

    localparam int NW    = 4;
    localparam int RATIO = 2;
    localparam int WW    = NW * RATIO;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;

    logic             in_ready0, in_ready1;
    logic [WW-1:0]    od0, od1;
    logic [RATIO-1:0] ok0, ok1;
    logic             ol0, ol1, ov0, ov1;
`ifdef N2W_WORD_CNT_EN
    logic [15:0]      wc0, wc1;
`endif

    always #5 clk = ~clk;

    narrow2wide_pack #(.NW(NW), .RATIO(RATIO), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready0), .out_data(od0), .out_keep(ok0),
        .out_last(ol0), .out_valid(ov0), .out_ready(out_ready)
`ifdef N2W_WORD_CNT_EN
        , .word_cnt(wc0)
`endif
    );

    narrow2wide_pack #(.NW(NW), .RATIO(RATIO), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready1), .out_data(od1), .out_keep(ok1),
        .out_last(ol1), .out_valid(ov1), .out_ready(out_ready)
`ifdef N2W_WORD_CNT_EN
        , .word_cnt(wc1)
`endif
    );

    typedef struct {
        logic [WW-1:0]    dm;
        logic [WW-1:0]    dl;
        logic [RATIO-1:0] keep;
        logic             last;
    } word_t;

    word_t         exp_q[$];
    word_t         got_q[$];
    logic [NW-1:0] beats[$];
    int            exp_wc = 0;
    bit            chk_en = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // Model: queue of words the consumer is owed, built from the beats with plain arithmetic.
    always @(posedge clk) begin
        bit    rdy;
        word_t w;
        int    nb;
        if (!rst_n) begin
            exp_q.delete();
            beats.delete();
            exp_wc = 0;
        end else begin
            rdy = (exp_q.size() == 0) || out_ready;
            if (exp_q.size() != 0 && out_ready) begin
                exp_q.delete(0);
                exp_wc = (exp_wc + 1) % 65536;
            end
            if (in_valid && rdy) begin
                beats.push_back(in_data);
                if (in_last || beats.size() == RATIO) begin
                    nb = beats.size();
                    w.dm = '0;
                    w.dl = '0;
                    for (int k = 0; k < nb; k++) begin
                        w.dm = w.dm | (WW'(beats[k]) << (WW - (k + 1) * NW));
                        w.dl = w.dl | (WW'(beats[k]) << (k * NW));
                    end
                    w.keep = RATIO'((1 << nb) - 1);
                    w.last = in_last;
                    exp_q.push_back(w);
                    beats.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_v;
        word_t g;
        if (chk_en) begin
            exp_v = (exp_q.size() != 0);
            chk("in_ready_msb", in_ready0, !exp_v || out_ready);
            chk("in_ready_lsb", in_ready1, !exp_v || out_ready);
            chk("out_valid_msb", ov0, exp_v);
            chk("out_valid_lsb", ov1, exp_v);
            if (exp_v) begin
                chk("out_data_msb", od0, exp_q[0].dm);
                chk("out_data_lsb", od1, exp_q[0].dl);
                chk("out_keep_msb", ok0, exp_q[0].keep);
                chk("out_keep_lsb", ok1, exp_q[0].keep);
                chk("out_last_msb", ol0, exp_q[0].last);
                chk("out_last_lsb", ol1, exp_q[0].last);
            end
`ifdef N2W_WORD_CNT_EN
            chk("word_cnt_msb", wc0, exp_wc);
            chk("word_cnt_lsb", wc1, exp_wc);
`endif
            if (ov0 && out_ready) begin
                g.dm = od0; g.dl = od1; g.keep = ok0; g.last = ol0;
                got_q.push_back(g);
            end
        end
    end

    // Hold the beat until the model says it is taken, then idle the bus with X.
    task automatic send(input logic [NW-1:0] d, input logic l);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            done = (exp_q.size() == 0) || out_ready;
            @(posedge clk);
            n++;
        end
        #1;
        if (!done) begin
            n_chk++;
            $display("FAIL send_timeout: beat %0h not accepted within %0d cycles", d, n);
        end
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'bx;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Literal word log expected from the directed sequence below.
    logic [WW-1:0]    lit_dm[9]   = '{8'hA5, 8'h3C, 8'h70, 8'h12, 8'hA5, 8'h96, 8'hA5, 8'h3C, 8'h12};
    logic [WW-1:0]    lit_dl[9]   = '{8'h5A, 8'hC3, 8'h07, 8'h21, 8'h5A, 8'h69, 8'h5A, 8'hC3, 8'h21};
    logic [RATIO-1:0] lit_keep[9] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic             lit_last[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int w;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", ov0, 0);
        chk("reset_out_data", od0, 0);
        chk("reset_out_keep", ok0, 0);
        chk("reset_out_last", ol0, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Two full words back to back.
        out_ready = 1'b1;
        send(4'hA, 1'b0); send(4'h5, 1'b0); send(4'h3, 1'b0); send(4'hC, 1'b0);

        // Early last on beat 0, then a full word.
        send(4'h7, 1'b1);
        send(4'h1, 1'b0); send(4'h2, 1'b0);

        // Idle gap mid-word.
        send(4'hA, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send(4'h5, 1'b0);

        // Last on the final lane.
        send(4'h9, 1'b0); send(4'h6, 1'b1);

        // Consumer stall, then release.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                send(4'hA, 1'b0); send(4'h5, 1'b0); send(4'h3, 1'b0); send(4'hC, 1'b0);
            end
            begin
                w = 0;
                while (!ov0 && w < 50) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                repeat (3) @(posedge clk);
                #1;
                chk("stall_in_ready", in_ready0, 0);
                chk("stall_hold_data", od0, 8'hA5);
                out_ready = 1'b1;
            end
        join

        // Reset discards a held word.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(4'h4, 1'b0); send(4'h8, 1'b0);
        @(posedge clk);
        #1;
        pulse_reset();
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_data", od0, 0);
        chk("rst_out_keep", ok0, 0);
        chk("rst_out_last", ol0, 0);

        // Reset discards a partial word and restarts the lane count.
        out_ready = 1'b1;
        send(4'hF, 1'b0);
        pulse_reset();
        send(4'h1, 1'b0); send(4'h2, 1'b0);

        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (2) @(posedge clk);
        #1;

        chk("word_count", got_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("lit%0d_data_msb", i), got_q[i].dm, lit_dm[i]);
                chk($sformatf("lit%0d_data_lsb", i), got_q[i].dl, lit_dl[i]);
                chk($sformatf("lit%0d_keep", i), got_q[i].keep, lit_keep[i]);
                chk($sformatf("lit%0d_last", i), got_q[i].last, lit_last[i]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
